// File: rtl/risc_pkg.sv
// Shared definitions for the execute stage: datapath width, opcodes, ADD-family
// function codes, WB/M control field layouts and the ALU operation selector.
package risc_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_JLR = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1100;

    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_ADZ = 2'b01;
    localparam logic [1:0] FN_ADC = 2'b10;

    // WB field: [0] register write, [2:1] writeback source select
    localparam int WB_REG_WRITE = 0;
    localparam int WB_SRC_LO    = 1;
    localparam int WB_SRC_HI    = 2;
    // M field: [0] memory read, [1] memory write, [2] reserved
    localparam int M_READ       = 0;
    localparam int M_WRITE      = 1;
    localparam int M_RSVD       = 2;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_NAND   = 2'b01,
        ALU_PASS_B = 2'b10,
        ALU_ZERO   = 2'b11
    } alu_op_t;

    // Conditional ADD/NDU variants execute only when their flag is set.
    function automatic logic func_ok(input logic [1:0] fn, input logic c, input logic z);
        logic ok;
        case (fn)
            FN_ADD:  ok = 1'b1;
            FN_ADC:  ok = c;
            FN_ADZ:  ok = z;
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational execute arithmetic: add with carry-out, nand, pass-through of
// operand b, or constant zero; zero flag derived from the selected result.
module ex_alu
    import risc_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] sum_s;

    // Operation select
    always_comb begin
        sum_s  = {1'b0, a} + {1'b0, b};
        result = 16'h0000;
        carry  = 1'b0;
        case (op)
            ALU_ADD: begin
                result = sum_s[DATA_W-1:0];
                carry  = sum_s[DATA_W];
            end
            ALU_NAND:   result = ~(a & b);
            ALU_PASS_B: result = b;
            ALU_ZERO:   result = 16'h0000;
            default:    result = 16'h0000;
        endcase
    end

    assign zero = (result == 16'h0000);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: decodes the instruction into ALU operations, registers the
// result and pass-through fields, owns the C/Z flags and branch/squash sequencing.
module ex_stage
    import risc_pkg::*;
#(
    parameter int DATA_W = risc_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [3:0]        opcode_in,
    input  logic [DATA_W-1:0] inst_in,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [DATA_W-1:0] imm6_in,
    input  logic [DATA_W-1:0] imm9_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] pc_plus1_in,
    input  logic [2:0]        rd_in,
    input  logic [2:0]        wb_in,
    input  logic [2:0]        m_in,
    input  logic              stall,
    output logic [DATA_W-1:0] alu_out_reg,
    output logic [DATA_W-1:0] store_data_reg,
    output logic [DATA_W-1:0] pc_plus1_reg,
    output logic [2:0]        rd_reg,
    output logic [2:0]        wb_reg,
    output logic [2:0]        m_reg,
    output logic              valid_reg,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target
);

    logic [DATA_W-1:0] op_a_s, op_b_s, tgt_a_s, tgt_b_s;
    alu_op_t           alu_op_s, tgt_op_s;
    logic [DATA_W-1:0] alu_result_s, target_s;
    logic              alu_carry_s, alu_zero_s;
    logic              tgt_carry_unused_s, tgt_zero_unused_s;
    logic [DATA_W-3:0] inst_unused_s;
    logic              qual_s, upd_c_s, upd_z_s, branch_s;
    logic              live_s, exec_s, take_s;

    assign inst_unused_s = inst_in[DATA_W-1:2];

    // Decode opcode into operand/operation selects and flag/branch effects
    always_comb begin
        op_a_s   = data_a;
        op_b_s   = data_b;
        alu_op_s = ALU_ZERO;
        tgt_a_s  = pc_in;
        tgt_b_s  = imm6_in;
        tgt_op_s = ALU_ADD;
        qual_s   = 1'b1;
        upd_c_s  = 1'b0;
        upd_z_s  = 1'b0;
        branch_s = 1'b0;
        case (opcode_in)
            OP_ADD: begin
                alu_op_s = ALU_ADD;
                qual_s   = func_ok(inst_in[1:0], carry_flag, zero_flag);
                upd_c_s  = 1'b1;
                upd_z_s  = 1'b1;
            end
            OP_ADI: begin
                op_b_s   = imm6_in;
                alu_op_s = ALU_ADD;
                upd_c_s  = 1'b1;
                upd_z_s  = 1'b1;
            end
            OP_NDU: begin
                alu_op_s = ALU_NAND;
                qual_s   = func_ok(inst_in[1:0], carry_flag, zero_flag);
                upd_z_s  = 1'b1;
            end
            OP_LHI: begin
                op_b_s   = imm9_in;
                alu_op_s = ALU_PASS_B;
            end
            OP_LW, OP_SW: begin
                op_a_s   = data_b;
                op_b_s   = imm6_in;
                alu_op_s = ALU_ADD;
            end
            OP_BEQ: begin
                branch_s = (data_a == data_b);
            end
            OP_JAL: begin
                op_b_s   = pc_plus1_in;
                alu_op_s = ALU_PASS_B;
                tgt_b_s  = imm9_in;
                branch_s = 1'b1;
            end
            OP_JLR: begin
                op_b_s   = pc_plus1_in;
                alu_op_s = ALU_PASS_B;
                tgt_b_s  = data_b;
                tgt_op_s = ALU_PASS_B;
                branch_s = 1'b1;
            end
            default: begin
                alu_op_s = ALU_ZERO;
            end
        endcase
    end

    // A live instruction is valid and not the wrong-path slot after a taken branch
    assign live_s = valid_in & ~branch_taken;
    assign exec_s = live_s & qual_s;
    assign take_s = exec_s & branch_s;

    ex_alu u_alu (
        .a      (op_a_s),
        .b      (op_b_s),
        .op     (alu_op_s),
        .result (alu_result_s),
        .carry  (alu_carry_s),
        .zero   (alu_zero_s)
    );

    ex_alu u_target (
        .a      (tgt_a_s),
        .b      (tgt_b_s),
        .op     (tgt_op_s),
        .result (target_s),
        .carry  (tgt_carry_unused_s),
        .zero   (tgt_zero_unused_s)
    );

    // Output, flag and branch registers; stall freezes everything
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_out_reg    <= 16'h0000;
            store_data_reg <= 16'h0000;
            pc_plus1_reg   <= 16'h0000;
            rd_reg         <= 3'b000;
            wb_reg         <= 3'b000;
            m_reg          <= 3'b000;
            valid_reg      <= 1'b0;
            carry_flag     <= 1'b0;
            zero_flag      <= 1'b0;
            branch_taken   <= 1'b0;
            branch_target  <= 16'h0000;
        end else if (!stall) begin
            alu_out_reg    <= alu_result_s;
            store_data_reg <= data_a;
            pc_plus1_reg   <= pc_plus1_in;
            rd_reg         <= rd_in;
            wb_reg         <= wb_in;
            m_reg          <= m_in;
            valid_reg      <= exec_s;
            branch_taken   <= take_s;
            if (take_s) begin
                branch_target <= target_s;
            end
            if (exec_s && upd_c_s) begin
                carry_flag <= alu_carry_s;
            end
            if (exec_s && upd_z_s) begin
                zero_flag <= alu_zero_s;
            end
        end
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter: DATA_W, 16, datapath width; only 16 is supported.
REQ-002 clock  in  1  single rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 valid_in  in  1  instruction from register-read/execute register is live.
REQ-005 opcode_in  in  4  instruction opcode.
REQ-006 inst_in  in  16  full instruction word; bits [1:0] select ADD/ADC/ADZ.
REQ-007 data_a, data_b  in  16 each  operand values (rA, rB).
REQ-008 imm6_in, imm9_in  in  16 each  sign-extended 6-bit immediate; 9-bit immediate already zero-padded to bits [15:7].
REQ-009 pc_in, pc_plus1_in  in  16 each  instruction PC and PC+1.
REQ-010 rd_in  in  3  destination register; wb_in, m_in  in  3 each  writeback/memory control, passed through.
REQ-011 stall  in  1  downstream hold request.
REQ-012 alu_out_reg, store_data_reg, pc_plus1_reg  out  16 each  registered result, store data, PC+1.
REQ-013 rd_reg  out  3; wb_reg, m_reg  out  3 each; valid_reg  out  1  registered pass-through and validity.
REQ-014 carry_flag, zero_flag  out  1 each  architectural C and Z flags.
REQ-015 branch_taken  out  1; branch_target  out  16  registered redirect to fetch.

Function
REQ-016 Result, flags and branch outputs SHALL update one clock after the input is sampled; latency is exactly 1 cycle.
REQ-017 ADD (0000), inst_in[1:0]=00: 17-bit sum data_a+data_b; alu_out = sum[15:0]; C = sum[16]; Z = (sum[15:0]==0).
REQ-018 ADC (0000, [1:0]=10) SHALL execute as ADD only when carry_flag=1; ADZ ([1:0]=01) only when zero_flag=1; otherwise valid_reg=0 and flags unchanged.
REQ-019 ADI (0001): data_a+imm6_in; C and Z updated.
REQ-020 NDU (0010): ~(data_a & data_b); Z updated, C unchanged; ADC/ADZ-style qualification applies on [1:0].
REQ-021 LHI (0011): alu_out = imm9_in; flags unchanged.
REQ-022 LW (0100)/SW (0101): alu_out = data_b+imm6_in (address, no flag update); store_data_reg = data_a.
REQ-023 BEQ (1100): branch taken when data_a==data_b; target = pc_in+imm6_in.
REQ-024 JAL (1000): always taken; target = pc_in+imm9_in; alu_out = pc_plus1_in.
REQ-025 JLR (1001): always taken; target = data_b; alu_out = pc_plus1_in.
REQ-026 Flags and alu_out SHALL be visible to the very next instruction, so a dependent ADC/ADZ back-to-back uses the updated flag.
REQ-027 The instruction presented in the cycle branch_taken=1 is wrong-path; it SHALL be squashed (valid_reg=0, no flag update, no branch).
REQ-028 branch_taken SHALL be a one-cycle pulse when stall=0.
REQ-029 valid_in=0 SHALL produce valid_reg=0, with flags and branch state unchanged and branch_taken=0.
REQ-030 stall=1 SHALL freeze every output register, the flags and branch_taken; inputs are ignored.
REQ-031 Unlisted opcodes SHALL pass through with alu_out=0, no flag change, and no branch.

Reset
REQ-032 When reset asserts, all outputs and the flags SHALL clear to 0 asynchronously; the first instruction is sampled on the first rising edge after deassertion.
REQ-033 Reset mid-branch SHALL clear branch_taken and the squash state; no wrong-path squash occurs after reset.

Structure
REQ-034 Opcode constants, the ADD/ADC/ADZ function codes, DATA_W, and the WB/M field layouts SHALL reside in shared package risc_pkg.
REQ-035 Combinational arithmetic SHALL be in the sub-module ex_alu (operands, op select -> result, carry, zero); ex_stage holds the registers, flags and branch/squash sequencing.

Verification
REQ-036 ADD a=FFFF, b=0001 -> alu_out 0000, C=1, Z=1 next cycle; following ADC a=0002, b=0003 -> 0005, valid_reg=1.
REQ-037 ADC with C=0 -> valid_reg=0, alu_out don't-care, C and Z held.
REQ-038 BEQ a=b=0010, pc=0020, imm6=FFFE -> branch_taken=1 for one cycle, target 001E; the next-cycle ADD is squashed.
REQ-039 JLR pc_plus1=0031, b=0100 -> target 0100, alu_out 0031; then stall=1 for 3 cycles -> all outputs held, branch_taken remains 1.
REQ-040 Reset asserted between clock edges during JAL -> outputs immediately 0, flags 0; no squash after release.
